axi_sram_slave: RTL and testbench
=================================

// Module: axi_sram_slave
// PURPOSE
//  AXI4 responder (slave) backed by a word-addressed 32-bit SRAM array; the far end of the data-side
//  AR/R/AW/W/B master channels (no IDs, no resp fields), for SoC simulation and FPGA bring-up.
//  Independent read and write engines, one outstanding burst per direction, INCR bursts only.
// PARAMETERS
//  MEM_AW     12  log2 of memory depth in 32-bit words (default 4096 words = 16 KiB)
//  RD_DELAY    3  extra wait cycles before first R beat / before AWREADY (only with AXI_SLV_DELAY_EN)
// PORTS
//  clk      in   1   clock
//  rst      in   1   synchronous reset, active-high
//  araddr   in  32   read burst byte address
//  arlen    in   8   read beats minus 1
//  arsize   in   3   bytes per beat = 1<<arsize (0..2 legal)
//  arvalid  in   1   AR valid
//  arready  out  1   AR ready
//  rdata    out 32   read data (full aligned word)
//  rlast    out  1   last read beat
//  rvalid   out  1   R valid
//  rready   in   1   R ready
//  awaddr   in  32   write burst byte address
//  awlen    in   8   write beats minus 1
//  awsize   in   3   bytes per beat = 1<<awsize (0..2 legal)
//  awvalid  in   1   AW valid
//  awready  out  1   AW ready
//  wdata    in  32   write data, lanes selected by wstrb
//  wstrb    in   4   byte write strobes
//  wlast    in   1   last write beat (informational, see behaviour)
//  wvalid   in   1   W valid
//  wready   out  1   W ready
//  bvalid   out  1   write response valid
//  bready   in   1   B ready
// BEHAVIOUR
//  - Reset: arready=awready=wready=rvalid=rlast=bvalid=0, rdata=0, both FSMs idle; memory not cleared.
//    arready/awready rise the first cycle after rst drops. rst mid-burst aborts burst, no B issued.
//  - Word index = addr[MEM_AW+1:2]; addresses beyond depth wrap modulo 2^MEM_AW words.
//  - Read FSM R_IDLE -> R_BURST -> R_IDLE. R_IDLE: arready=1; on arvalid&arready latch addr, len,
//    size, beat cnt=0, go R_BURST, arready=0. R_BURST: rvalid=1 from cycle after AR handshake
//    (latency 1), rdata=registered mem[word index], rlast=(cnt==len). On rvalid&rready: addr+=1<<size,
//    cnt+=1, next rdata loaded same cycle (back-to-back beats, no bubble). rvalid/rdata held stable
//    while rready=0. Handshake with rlast=1 -> R_IDLE; arready=1 next cycle.
//  - Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE. W_IDLE: awready=1; on handshake latch addr, len,
//    size, cnt=0. W_DATA: wready=1; each wvalid&wready writes bytes where wstrb[i]=1 to mem[word index],
//    addr+=1<<size, cnt+=1. Burst ends on beat cnt==len regardless of wlast (early/late wlast ignored).
//    W_RESP: bvalid=1 held until bready; then W_IDLE, awready=1 next cycle. W beats arriving before AW
//    handshake are not accepted (wready=0).
//  - Narrow beats: address increments by 1<<size; sub-word reads return the whole aligned word.
//    arsize/awsize >2 treated as 2.
//  - Read and write engines run concurrently. Same word read and written in one cycle: R beat issued
//    that cycle carries old data; next read beat sees new data.
//  - arlen=0 / awlen=0: single beat, rlast=1 on first beat.
// CONFIGURATION
//  AXI_SLV_DELAY_EN defined: R_BURST waits RD_DELAY cycles (rvalid=0) before first beat of every burst,
//  and W_IDLE holds awready=0 for RD_DELAY cycles after awvalid first seen, to exercise master stalls.
//  Undefined: no wait states; latencies exactly as above (first R beat 1 cycle after AR handshake).
// TESTING
//  1 Single write awaddr=0x100,awlen=0,wstrb=4'hF,wdata=0xDEADBEEF; read araddr=0x100 -> rdata=0xDEADBEEF,
//    rlast=1, bvalid exactly one cycle after W handshake.
//  2 8-beat write 0x200..0x21C data 0..7, then 8-beat read, rready=1 -> 8 consecutive beats 0..7,
//    rlast only on beat 8, arready=0 throughout burst.
//  3 Byte strobes: write 0x11223344 full, then wstrb=4'b0010 wdata=0x0000AA00 -> read 0x1122AA44.
//  4 rready toggled 1-0-1 during 4-beat read -> rdata/rlast stable while stalled, no beat lost/duplicated.
//  5 Concurrent 4-beat read of 0x300 and 4-beat write to 0x400 -> both complete, data independent;
//    address 0x4000 (MEM_AW=12) aliases 0x0000.
//  6 rst asserted mid 8-beat read -> rvalid=0 next cycle, arready=1 after release, new burst correct;
//    with AXI_SLV_DELAY_EN first rvalid exactly RD_DELAY+1 cycles after AR handshake.

Source files
------------

// File: rtl/axi_sram_slave.sv
// AXI4 responder backed by a word-addressed 32-bit SRAM array.
// Independent read/write engines, one INCR burst per direction.
//
// Parameters:
//   MEM_AW   log2 of memory depth in 32-bit words
//   RD_DELAY wait cycles before first R beat / before awready
//            (used only when AXI_SLV_DELAY_EN is defined)
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   araddr/arlen/arsize       read burst request (arvalid/arready)
//   rdata/rlast               read beat (rvalid/rready)
//   awaddr/awlen/awsize       write burst request (awvalid/awready)
//   wdata/wstrb/wlast         write beat (wvalid/wready)
//   bvalid/bready             write response
// Build option: define AXI_SLV_DELAY_EN to insert master-stall wait
// states; undefined, the responder runs with no wait states.
module axi_sram_slave #(
  parameter int MEM_AW   = 12,
  parameter int RD_DELAY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic        bvalid,
  input  logic        bready
);

  localparam int DEPTH = 1 << MEM_AW;

`ifdef AXI_SLV_DELAY_EN
  localparam logic [7:0] DLY = 8'(RD_DELAY);
`else
  localparam logic [7:0] DLY = 8'd0;
`endif

  typedef enum logic [0:0] {
    R_IDLE,
    R_BURST
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  function automatic logic [1:0] clamp_size(
    input logic [2:0] s
  );
    return (s > 3'd2) ? 2'd2 : s[1:0];
  endfunction

  function automatic logic [31:0] step(
    input logic [1:0] s
  );
    return 32'd1 << s;
  endfunction

  function automatic logic [MEM_AW-1:0] widx(
    input logic [31:0] a
  );
    return a[MEM_AW+1:2];
  endfunction

  logic [31:0] mem [DEPTH];

  // Burst termination is counted from awlen; wlast is not needed.
  logic unused;
  assign unused = wlast;

  // ---------------- read engine ----------------
  r_state_e    r_state;
  r_state_e    r_next;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [7:0]  r_cnt;
  logic [7:0]  r_dly;
  logic [1:0]  r_size;
  logic [31:0] rdata_q;

  logic        ar_hs;
  logic        r_hs;
  logic        r_load;
  logic [31:0] r_ld_addr;
  logic [31:0] r_fwd;

  // ---------------- write engine ---------------
  w_state_e    w_state;
  w_state_e    w_next;
  logic [31:0] w_addr;
  logic [7:0]  w_len;
  logic [7:0]  w_cnt;
  logic [7:0]  aw_dly;
  logic [1:0]  w_size;

  logic        aw_hs;
  logic        w_hs;

  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        arready = !rst;
        if (arvalid && !rst) r_next = R_BURST;
      end
      R_BURST: begin
        rvalid = !rst && (r_dly == 8'd0);
        rlast  = rvalid && (r_cnt == r_len);
        if (rvalid && rready && rlast)
          r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // rdata is refilled whenever the next beat's word becomes known:
  // at AR accept, at the end of the wait window, and on each
  // non-final beat handshake.
  always_comb begin
    r_load    = 1'b0;
    r_ld_addr = r_addr;
    if (ar_hs) begin
      r_load    = 1'b1;
      r_ld_addr = araddr;
    end else if (r_state == R_BURST && r_dly == 8'd1) begin
      r_load    = 1'b1;
      r_ld_addr = r_addr;
    end else if (r_hs && !rlast) begin
      r_load    = 1'b1;
      r_ld_addr = r_addr + step(r_size);
    end
  end

  // A write landing on the word being fetched is merged in, so the
  // beat after a same-cycle write observes the new bytes.
  always_comb begin
    r_fwd = mem[widx(r_ld_addr)];
    for (int i = 0; i < 4; i++) begin
      if (w_hs && wstrb[i] &&
          widx(w_addr) == widx(r_ld_addr))
        r_fwd[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= 32'd0;
      r_len   <= 8'd0;
      r_cnt   <= 8'd0;
      r_dly   <= 8'd0;
      r_size  <= 2'd0;
      rdata_q <= 32'd0;
    end else begin
      if (ar_hs) begin
        r_addr <= araddr;
        r_len  <= arlen;
        r_size <= clamp_size(arsize);
        r_cnt  <= 8'd0;
        r_dly  <= DLY;
      end else if (r_state == R_BURST) begin
        if (r_dly != 8'd0) r_dly <= r_dly - 8'd1;
        if (r_hs) begin
          r_addr <= r_addr + step(r_size);
          r_cnt  <= r_cnt + 8'd1;
        end
      end
      if (r_load) rdata_q <= r_fwd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        awready = !rst && (aw_dly == DLY);
        if (awvalid && awready) w_next = W_DATA;
      end
      W_DATA: begin
        wready = !rst;
        if (wvalid && wready && w_cnt == w_len)
          w_next = W_RESP;
      end
      W_RESP: begin
        bvalid = !rst;
        if (bvalid && bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_addr <= 32'd0;
      w_len  <= 8'd0;
      w_cnt  <= 8'd0;
      w_size <= 2'd0;
      aw_dly <= 8'd0;
    end else begin
      if (aw_hs) begin
        w_addr <= awaddr;
        w_len  <= awlen;
        w_size <= clamp_size(awsize);
        w_cnt  <= 8'd0;
        aw_dly <= 8'd0;
      end else if (w_state == W_IDLE && awvalid &&
                   aw_dly != DLY) begin
        aw_dly <= aw_dly + 8'd1;
      end
      if (w_hs) begin
        w_addr <= w_addr + step(w_size);
        w_cnt  <= w_cnt + 8'd1;
      end
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i])
          mem[widx(w_addr)][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave.
// Drives and samples on the falling clock edge.
module tb_axi_sram_slave;

  localparam int TMO = 50;
`ifdef AXI_SLV_DELAY_EN
  localparam int R_LAT   = 3 + 1;
  localparam int AWR_RST = 0;
`else
  localparam int R_LAT   = 1;
  localparam int AWR_RST = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] wbuf [16];
  logic [3:0]  wsb  [16];
  logic [31:0] rexp [16];

  always #5 clk = ~clk;

  axi_sram_slave #(
    .MEM_AW   (12),
    .RD_DELAY (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .araddr  (araddr),
    .arlen   (arlen),
    .arsize  (arsize),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready),
    .awaddr  (awaddr),
    .awlen   (awlen),
    .awsize  (awsize),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wlast   (wlast),
    .wvalid  (wvalid),
    .wready  (wready),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic axi_wr(
    input logic [31:0] a,
    input int          len,
    input logic [2:0]  sz
  );
    int t;
    chk("w_idle", 32'(wready), 0);
    awaddr  = a;
    awlen   = 8'(len);
    awsize  = sz;
    awvalid = 1'b1;
    t = 0;
    while (!awready && t < TMO) begin
      @(negedge clk);
      t++;
    end
    chk("aw_tmo", 32'(t < TMO), 1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wdata  = wbuf[i];
      wstrb  = wsb[i];
      wlast  = (i == len);
      wvalid = 1'b1;
      t = 0;
      while (!wready && t < TMO) begin
        @(negedge clk);
        t++;
      end
      chk("w_tmo", 32'(t < TMO), 1);
      chk("b_early", 32'(bvalid), 0);
      @(negedge clk);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    chk("bvalid", 32'(bvalid), 1);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("b_done", 32'(bvalid), 0);
  endtask

  task automatic axi_rd(
    input logic [31:0] a,
    input int          len,
    input logic [2:0]  sz,
    input bit          stall
  );
    int t;
    int lat;
    araddr  = a;
    arlen   = 8'(len);
    arsize  = sz;
    arvalid = 1'b1;
    t = 0;
    while (!arready && t < TMO) begin
      @(negedge clk);
      t++;
    end
    chk("ar_tmo", 32'(t < TMO), 1);
    @(negedge clk);
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < TMO) begin
      @(negedge clk);
      lat++;
    end
    chk("r_lat", 32'(lat), 32'(R_LAT));
    for (int i = 0; i <= len; i++) begin
      if (stall && i == 1) begin
        rready = 1'b0;
        repeat (2) begin
          @(negedge clk);
          chk("stl_v", 32'(rvalid), 1);
          chk("stl_d", rdata, rexp[i]);
          chk("stl_l", 32'(rlast), 32'(i == len));
        end
      end
      rready = 1'b1;
      t = 0;
      while (!rvalid && t < TMO) begin
        @(negedge clk);
        t++;
      end
      if (i > 0) chk("r_b2b", 32'(t), 0);
      chk("rdata", rdata, rexp[i]);
      chk("rlast", 32'(rlast), 32'(i == len));
      chk("ar_busy", 32'(arready), 0);
      @(negedge clk);
    end
    rready = 1'b0;
    chk("r_done", 32'(rvalid), 0);
    chk("ar_idle", 32'(arready), 1);
  endtask

  initial begin
    rst     = 1'b1;
    araddr  = '0;
    arlen   = '0;
    arsize  = '0;
    arvalid = 1'b0;
    rready  = 1'b0;
    awaddr  = '0;
    awlen   = '0;
    awsize  = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    wlast   = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_arrdy", 32'(arready), 0);
    chk("rst_awrdy", 32'(awready), 0);
    chk("rst_wrdy",  32'(wready), 0);
    chk("rst_rvld",  32'(rvalid), 0);
    chk("rst_rlast", 32'(rlast), 0);
    chk("rst_bvld",  32'(bvalid), 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_arrdy", 32'(arready), 1);
    chk("rel_awrdy", 32'(awready), 32'(AWR_RST));

    // single beat
    wbuf[0] = 32'hDEADBEEF;
    wsb[0]  = 4'hF;
    axi_wr(32'h100, 0, 3'd2);
    rexp[0] = 32'hDEADBEEF;
    axi_rd(32'h100, 0, 3'd2, 1'b0);

    // 8-beat burst
    for (int i = 0; i < 8; i++) begin
      wbuf[i] = 32'(i);
      wsb[i]  = 4'hF;
      rexp[i] = 32'(i);
    end
    axi_wr(32'h200, 7, 3'd2);
    axi_rd(32'h200, 7, 3'd2, 1'b0);

    // byte strobes
    wbuf[0] = 32'h11223344;
    wsb[0]  = 4'hF;
    axi_wr(32'h500, 0, 3'd2);
    wbuf[0] = 32'h0000AA00;
    wsb[0]  = 4'b0010;
    axi_wr(32'h500, 0, 3'd2);
    rexp[0] = 32'h1122AA44;
    axi_rd(32'h500, 0, 3'd2, 1'b0);

    // narrow byte beats into one word
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = {4{8'(8'h10 + i)}};
      wsb[i]  = 4'(1 << i);
      rexp[i] = 32'h13121110;
    end
    axi_wr(32'h600, 3, 3'd0);
    axi_rd(32'h600, 3, 3'd0, 1'b0);

    // rready stall
    for (int i = 0; i < 4; i++) rexp[i] = 32'(i);
    axi_rd(32'h200, 3, 3'd2, 1'b1);

    // concurrent read and write
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 32'hA0 + 32'(i);
      wsb[i]  = 4'hF;
    end
    axi_wr(32'h300, 3, 3'd2);
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 32'hB0 + 32'(i);
      rexp[i] = 32'hA0 + 32'(i);
    end
    fork
      axi_wr(32'h400, 3, 3'd2);
      axi_rd(32'h300, 3, 3'd2, 1'b0);
    join
    for (int i = 0; i < 4; i++) rexp[i] = 32'hB0 + 32'(i);
    axi_rd(32'h400, 3, 3'd2, 1'b0);

    // aliasing past the array depth
    wbuf[0] = 32'h5A5A0001;
    wsb[0]  = 4'hF;
    axi_wr(32'h4000, 0, 3'd2);
    rexp[0] = 32'h5A5A0001;
    axi_rd(32'h0000, 0, 3'd2, 1'b0);
    rexp[0] = 32'hDEADBEEF;
    axi_rd(32'h4100, 0, 3'd2, 1'b0);

    // reset in the middle of a read burst
    araddr  = 32'h200;
    arlen   = 8'd7;
    arsize  = 3'd2;
    arvalid = 1'b1;
    begin
      int t;
      t = 0;
      while (!arready && t < TMO) begin
        @(negedge clk);
        t++;
      end
      chk("m_ar_tmo", 32'(t < TMO), 1);
      @(negedge clk);
      arvalid = 1'b0;
      t = 0;
      while (!rvalid && t < TMO) begin
        @(negedge clk);
        t++;
      end
      chk("m_r_tmo", 32'(t < TMO), 1);
    end
    rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("m_rdata", rdata, 32'(i));
      @(negedge clk);
    end
    rst    = 1'b1;
    rready = 1'b0;
    @(negedge clk);
    chk("m_rvld", 32'(rvalid), 0);
    chk("m_arrdy", 32'(arready), 0);
    chk("m_rdat0", rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("m_arrel", 32'(arready), 1);
    chk("m_rvld2", 32'(rvalid), 0);
    for (int i = 0; i < 4; i++) rexp[i] = 32'(i);
    axi_rd(32'h200, 3, 3'd2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
